phase_meas_ctrl: RTL
====================

# phase_meas_ctrl

Sequencer for voltage/current phase measurement. It pairs voltage and current edge timestamps, forms the signed time offset, scales it by 360 and drives a shared multi-cycle divider through a start/done handshake. It publishes a signed phase in degrees with a one-cycle valid pulse. It sits between the edge-timestamp capture units and the shared divider, gated by the frequency tracker's `fre_done`.

## Interface
- `TW`, 32, timestamp/period width (unsigned, free-running counter domain)
- `DEG_SCALE`, 360, phase full-scale multiplier
- `PAIR_TIMEOUT`, 4096, max cycles between first and second edge of a pair
- `clk` in 1 — single clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `fre_done` in 1 — level; period measurement valid, enables measurement
- `v_period_time` in TW — voltage period in clk ticks, sampled at pair completion
- `v_edge_valid` in 1 — one-cycle pulse, `v_edge_time` valid
- `v_edge_time` in TW — voltage edge timestamp
- `i_edge_valid` in 1 — one-cycle pulse, `i_edge_time` valid
- `i_edge_time` in TW — current edge timestamp
- `div_start` out 1 — one-cycle request to shared divider
- `div_dividend` out 2*TW — unsigned |Δt|·DEG_SCALE, zero-extended
- `div_divisor` out TW — captured period
- `div_done` in 1 — one-cycle pulse, quotient valid
- `div_quotient` in TW — unsigned quotient
- `delta_t` out TW signed — i_time − v_time of last pair
- `phase_diff` out TW signed — degrees, positive = current lags
- `phase_valid` out 1 — one-cycle pulse when `phase_diff` updates
- `err` out 2 — one-cycle pulse code: 01 timeout, 10 bad period (0 or |Δt| ≥ period)

## Operation
- States: IDLE, WAIT_PAIR, MULT, DIV_REQ, DIV_WAIT, OUT, DRAIN.
- IDLE: leave when `fre_done`=1, to WAIT_PAIR with both capture flags clear.
- WAIT_PAIR: each edge pulse stores its timestamp and sets its flag. A repeat pulse on an already-flagged channel overwrites the timestamp and restarts the timeout counter. Both pulses in the same cycle are legal and complete the pair.
- Pair complete (both flags set) → MULT, latching `v_period_time` into the divisor register.
- MULT:
  - Δt = (i − v) mod 2^TW, interpreted as signed TW bits, so counter wrap is handled.
  - Store sign and |Δt|, and register `delta_t`.
  - If period = 0 or |Δt| ≥ period: pulse err=10, go to WAIT_PAIR, no divider request.
  - If Δt = 0: skip divider and go to OUT with quotient 0.
  - Otherwise compute the product |Δt|·DEG_SCALE at full 2*TW width and go to DIV_REQ.
- DIV_REQ: assert `div_start` for exactly one cycle with dividend and divisor stable, then go to DIV_WAIT. Dividend and divisor stay held until `div_done`.
- DIV_WAIT: on `div_done`, phase = sign ? −quotient : +quotient, then go to OUT.
- OUT: register `phase_diff`, pulse `phase_valid`, return to WAIT_PAIR with flags cleared.
- Timeout: in WAIT_PAIR with exactly one flag set, the counter reaching PAIR_TIMEOUT triggers err=01 and clears both flags.
- `fre_done` falling:
  - In WAIT_PAIR/MULT/DIV_REQ: go to IDLE immediately. `div_start` is not issued that cycle.
  - In DIV_WAIT: go to DRAIN, wait for `div_done`, discard the result, then go to IDLE.
- Edge pulses arriving outside WAIT_PAIR are ignored.
- Reset values: `div_start` 0, `div_dividend` 0, `div_divisor` 0, `delta_t` 0, `phase_diff` 0, `phase_valid` 0, `err` 0, state IDLE, flags and counters 0. Reset mid-transaction abandons any divider request without a drain; the divider shares `rst`.

## Timing
- Second edge sampled at edge N → MULT at N+1 → `div_start` high during cycle N+2.
- `div_done` at cycle D → `phase_valid` high at D+1, with `phase_diff` valid that same cycle.
- Δt = 0 path: `phase_valid` at N+2.
- Error pulses coincide with leaving MULT (N+1) or with the timeout cycle.
- Maximum throughput: one phase per (3 + divider latency) cycles. Edge pulses arriving during MULT..OUT are lost by design.

## Structure
- Shared package `fr_track_pkg`: state enum, `ERR_TIMEOUT`/`ERR_PERIOD` codes, `DEG_SCALE` default, `TW` default.
- Sub-module `edge_pair_capture`: owns flags, timestamps, overwrite logic and timeout counter. It outputs `pair_ready` and a timeout pulse.
- The FSM and arithmetic stay in the top module. The divider is external and shared.

## Test plan
- fre_done=1, v=1000, i=1100, period=2000, divider returns 18 after 5 cycles → `div_dividend`=36000, `div_divisor`=2000, `delta_t`=100, `phase_diff`=+18, one `phase_valid` at D+1.
- v=0x0000_0010, i=0xFFFF_FFF0 (wrap), period=1000 → `delta_t`=−32, dividend=11520, quotient 11 → `phase_diff`=−11.
- v and i pulses in the same cycle with equal times → no `div_start`, `phase_diff`=0, `phase_valid` 2 cycles later.
- Only v pulse, no i for PAIR_TIMEOUT cycles → err=01 for one cycle, no `div_start`, next pair measures normally.
- period=0 or |Δt|=period → err=10, no `div_start`.
- fre_done dropped during DIV_WAIT → no `phase_valid` after `div_done`, FSM returns to IDLE. Repeat with `rst` asserted mid-DIV_WAIT → all outputs at reset values next cycle.

Source files
------------

// File: rtl/fr_track_pkg.sv
// Shared types and defaults for the frequency/phase tracking blocks.
package fr_track_pkg;

  localparam int unsigned DEF_TW           = 32;
  localparam int unsigned DEF_DEG_SCALE    = 360;
  localparam int unsigned DEF_PAIR_TIMEOUT = 4096;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_PERIOD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PAIR,
    ST_MULT,
    ST_DIV_REQ,
    ST_DIV_WAIT,
    ST_OUT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/edge_pair_capture.sv
// Collects one voltage and one current edge timestamp and times out a half-complete pair.
module edge_pair_capture #(
  parameter int unsigned TW           = 32,
  parameter int unsigned PAIR_TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  input  logic          v_edge_valid,
  input  logic [TW-1:0] v_edge_time,
  input  logic          i_edge_valid,
  input  logic [TW-1:0] i_edge_time,
  output logic [TW-1:0] v_time,
  output logic [TW-1:0] i_time,
  output logic          pair_ready,
  output logic          timeout
);

  localparam int unsigned CW = $clog2(PAIR_TIMEOUT + 1);

  logic          v_flag;
  logic          i_flag;
  logic [CW-1:0] cnt;
  logic          any_edge;

  assign any_edge   = v_edge_valid | i_edge_valid;
  assign pair_ready = v_flag & i_flag;
  // A fresh edge in the expiry cycle wins over the timeout.
  assign timeout    = enable & (v_flag ^ i_flag) & ~any_edge &
                      (cnt >= CW'(PAIR_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      v_flag <= 1'b0;
      i_flag <= 1'b0;
      v_time <= '0;
      i_time <= '0;
      cnt    <= '0;
    end else if (clear) begin
      v_flag <= 1'b0;
      i_flag <= 1'b0;
      cnt    <= '0;
    end else if (enable) begin
      if (timeout) begin
        v_flag <= 1'b0;
        i_flag <= 1'b0;
        cnt    <= '0;
      end else begin
        if (v_edge_valid) begin
          v_flag <= 1'b1;
          v_time <= v_edge_time;
        end
        if (i_edge_valid) begin
          i_flag <= 1'b1;
          i_time <= i_edge_time;
        end
        if (any_edge) cnt <= '0;
        else if (v_flag ^ i_flag) cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/phase_meas_ctrl.sv
// Pairs V/I edges, scales the signed offset by DEG_SCALE and runs it through a shared divider.
module phase_meas_ctrl
  import fr_track_pkg::*;
#(
  parameter int unsigned TW           = DEF_TW,
  parameter int unsigned DEG_SCALE    = DEF_DEG_SCALE,
  parameter int unsigned PAIR_TIMEOUT = DEF_PAIR_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fre_done,
  input  logic [TW-1:0]        v_period_time,
  input  logic                 v_edge_valid,
  input  logic [TW-1:0]        v_edge_time,
  input  logic                 i_edge_valid,
  input  logic [TW-1:0]        i_edge_time,
  output logic                 div_start,
  output logic [2*TW-1:0]      div_dividend,
  output logic [TW-1:0]        div_divisor,
  input  logic                 div_done,
  input  logic [TW-1:0]        div_quotient,
  output logic signed [TW-1:0] delta_t,
  output logic signed [TW-1:0] phase_diff,
  output logic                 phase_valid,
  output logic [1:0]           err
);

  state_t         state;
  logic           start_r;
  logic           sign_r;
  logic [TW-1:0]  v_time;
  logic [TW-1:0]  i_time;
  logic           pair_ready;
  logic           timeout;
  logic           cap_enable;
  logic           cap_clear;
  logic [TW-1:0]  delta_c;
  logic [TW-1:0]  mag_c;
  logic           sign_c;
  logic [2*TW-1:0] product_c;

  assign cap_enable = (state == ST_WAIT_PAIR) & ~pair_ready;
  assign cap_clear  = (state != ST_WAIT_PAIR);

  edge_pair_capture #(
    .TW           (TW),
    .PAIR_TIMEOUT (PAIR_TIMEOUT)
  ) u_capture (
    .clk          (clk),
    .rst          (rst),
    .enable       (cap_enable),
    .clear        (cap_clear),
    .v_edge_valid (v_edge_valid),
    .v_edge_time  (v_edge_time),
    .i_edge_valid (i_edge_valid),
    .i_edge_time  (i_edge_time),
    .v_time       (v_time),
    .i_time       (i_time),
    .pair_ready   (pair_ready),
    .timeout      (timeout)
  );

  // Modular difference keeps the sign right across counter wrap.
  assign delta_c   = i_time - v_time;
  assign sign_c    = delta_c[TW-1];
  assign mag_c     = sign_c ? (~delta_c + TW'(1)) : delta_c;
  assign product_c = (2*TW)'(mag_c) * (2*TW)'(DEG_SCALE);

  // Losing fre_done in the request cycle suppresses the start pulse.
  assign div_start = start_r & fre_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      start_r      <= 1'b0;
      sign_r       <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      delta_t      <= '0;
      phase_diff   <= '0;
      phase_valid  <= 1'b0;
      err          <= ERR_NONE;
    end else begin
      start_r     <= 1'b0;
      phase_valid <= 1'b0;
      err         <= ERR_NONE;
      case (state)
        ST_IDLE: if (fre_done) state <= ST_WAIT_PAIR;
        ST_WAIT_PAIR: begin
          if (!fre_done) state <= ST_IDLE;
          else if (pair_ready) begin
            div_divisor <= v_period_time;
            state       <= ST_MULT;
          end else if (timeout) err <= ERR_TIMEOUT;
        end
        ST_MULT: begin
          delta_t <= $signed(delta_c);
          sign_r  <= sign_c;
          if (!fre_done) state <= ST_IDLE;
          else if (div_divisor == '0 || mag_c >= div_divisor) begin
            err   <= ERR_PERIOD;
            state <= ST_WAIT_PAIR;
          end else if (delta_c == '0) begin
            phase_diff  <= '0;
            phase_valid <= 1'b1;
            state       <= ST_OUT;
          end else begin
            div_dividend <= product_c;
            start_r      <= 1'b1;
            state        <= ST_DIV_REQ;
          end
        end
        ST_DIV_REQ: state <= fre_done ? ST_DIV_WAIT : ST_IDLE;
        ST_DIV_WAIT: begin
          if (div_done) begin
            if (fre_done) begin
              phase_diff  <= sign_r ? $signed(~div_quotient + TW'(1)) : $signed(div_quotient);
              phase_valid <= 1'b1;
              state       <= ST_OUT;
            end else state <= ST_IDLE;
          end else if (!fre_done) state <= ST_DRAIN;
        end
        ST_OUT:   state <= ST_WAIT_PAIR;
        ST_DRAIN: if (div_done) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
